// File: rtl/pid_chn_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : pid_chn_scheduler
//  Description : Runs one control round per tick. Each active channel is
//                issued to the shared PID core in ascending order, and the
//                scheduler waits for that channel's result before moving on.
//                Produces the PWM stop mask and the brake request, plus
//                sticky overrun and timeout flags.
//                Optional build macro: PID_TIMEOUT_EN (per-channel response
//                timeout with fault masking).
//  Revision    : 1.0 - initial release
// ============================================================================
module pid_chn_scheduler #(
    parameter int CLK_FREQ       = 27_000_000,
    parameter int CTRL_FREQ      = 100,
    parameter int NUM_CHN        = 4,
    parameter int CHN_WIDTH      = 3,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic [NUM_CHN-1:0]    chn_mask,
    output logic                  pid_start,
    output logic [CHN_WIDTH-1:0]  pid_chn,
    input  logic                  pid_ready,
    input  logic                  u_valid_o,
    input  logic [CHN_WIDTH-1:0]  u_chn_o,
    input  logic [DATA_WIDTH-1:0] u_data_o,
    output logic [NUM_CHN-1:0]    stop,
    output logic                  brake,
    output logic                  busy,
    output logic                  round_done,
    output logic                  overrun_err,
    output logic                  timeout_err
);

    localparam int TICK_PERIOD = CLK_FREQ / CTRL_FREQ - 1;
    localparam int TCK_W       = (TICK_PERIOD > 0) ? $clog2(TICK_PERIOD + 1) : 1;
    localparam int TO_W        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
`ifdef PID_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_TICK = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_RESP = 3'd3,
        S_NEXT      = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [TCK_W-1:0]       cnt_q, cnt_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic [CHN_WIDTH-1:0]   ptr_q, ptr_d;
    logic [NUM_CHN-1:0]     round_mask_q, round_mask_d;
    logic [NUM_CHN-1:0]     fault_q, fault_d;
    logic [NUM_CHN-1:0]     zero_q, zero_d;
    logic                   pid_start_q, pid_start_d;
    logic [CHN_WIDTH-1:0]   pid_chn_q, pid_chn_d;
    logic [NUM_CHN-1:0]     stop_q, stop_d;
    logic                   brake_q, brake_d;
    logic                   busy_q, busy_d;
    logic                   round_done_q, round_done_d;
    logic                   overrun_q, overrun_d;
    logic                   timeout_q, timeout_d;

    logic                   w_tick;
    logic [NUM_CHN-1:0]     w_live;
    logic [NUM_CHN-1:0]     w_above;
    logic [NUM_CHN-1:0]     w_next;
    logic [NUM_CHN-1:0]     w_start_set;
    logic [NUM_CHN-1:0]     w_ptr_oh;

    // Lowest set bit of a channel mask, as a channel index
    function automatic logic [CHN_WIDTH-1:0] pick_low(input logic [NUM_CHN-1:0] m);
        pick_low = '0;
        for (int i = NUM_CHN - 1; i >= 0; i--) begin
            if (m[i]) pick_low = CHN_WIDTH'(i);
        end
    endfunction

    // Control-period divider; parked at zero while disabled
    always_comb begin
        w_tick = enable && (cnt_q == TCK_W'(TICK_PERIOD));
        if (!enable || w_tick) cnt_d = '0;
        else                   cnt_d = cnt_q + 1'b1;
    end

    // Channel selection helpers: live set, channels above ptr, next candidate
    always_comb begin
        w_live      = round_mask_q & ~fault_q;
        w_start_set = chn_mask & ~fault_q;
        w_ptr_oh    = NUM_CHN'(1) << ptr_q;
        w_above     = '0;
        for (int i = 0; i < NUM_CHN; i++) begin
            w_above[i] = (CHN_WIDTH'(i) > ptr_q);
        end
        w_next = w_live & w_above;
    end

    // Round sequencer: next state and registered outputs
    always_comb begin
        state_d      = state_q;
        to_cnt_d     = to_cnt_q;
        ptr_d        = ptr_q;
        round_mask_d = round_mask_q;
        fault_d      = fault_q;
        zero_d       = zero_q;
        pid_start_d  = pid_start_q;
        pid_chn_d    = pid_chn_q;
        stop_d       = stop_q;
        brake_d      = brake_q;
        busy_d       = busy_q;
        round_done_d = 1'b0;
        overrun_d    = overrun_q;
        timeout_d    = timeout_q;

        // A tick landing inside a round is dropped but remembered
        if (w_tick && busy_q) overrun_d = 1'b1;

        if (!enable) begin
            state_d      = S_IDLE;
            to_cnt_d     = '0;
            ptr_d        = '0;
            round_mask_d = '0;
            fault_d      = '0;
            zero_d       = '0;
            pid_start_d  = 1'b0;
            pid_chn_d    = '0;
            stop_d       = '1;
            brake_d      = 1'b1;
            busy_d       = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    stop_d  = '1;
                    brake_d = 1'b1;
                    state_d = S_WAIT_TICK;
                end
                S_WAIT_TICK: begin
                    if (w_tick) begin
                        round_mask_d = chn_mask;
                        stop_d       = ~chn_mask | fault_q;
                        zero_d       = '0;
                        ptr_d        = pick_low(w_start_set);
                        if (w_start_set == '0) begin
                            round_done_d = 1'b1;
                        end else begin
                            busy_d      = 1'b1;
                            pid_start_d = 1'b1;
                            pid_chn_d   = pick_low(w_start_set);
                            state_d     = S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    // pid_start/pid_chn stay put until the core accepts
                    if (pid_ready) begin
                        pid_start_d = 1'b0;
                        to_cnt_d    = '0;
                        state_d     = S_WAIT_RESP;
                    end
                end
                S_WAIT_RESP: begin
                    if (u_valid_o && (u_chn_o == ptr_q)) begin
                        if (u_data_o == '0) zero_d = zero_q | w_ptr_oh;
                        else                zero_d = zero_q & ~w_ptr_oh;
                        state_d = S_NEXT;
                    end else if (TO_EN && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1))) begin
                        timeout_d = 1'b1;
                        fault_d   = fault_q | w_ptr_oh;
                        stop_d    = stop_q | w_ptr_oh;
                        state_d   = S_NEXT;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (w_next != '0) begin
                        ptr_d       = pick_low(w_next);
                        pid_chn_d   = pick_low(w_next);
                        pid_start_d = 1'b1;
                        state_d     = S_ISSUE;
                    end else begin
                        // Brake only if every live channel asked for zero drive
                        round_done_d = 1'b1;
                        busy_d       = 1'b0;
                        brake_d      = ((w_live & ~zero_q) == '0);
                        state_d      = S_WAIT_TICK;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers, asynchronously reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            to_cnt_q     <= '0;
            ptr_q        <= '0;
            round_mask_q <= '0;
            fault_q      <= '0;
            zero_q       <= '0;
            pid_start_q  <= 1'b0;
            pid_chn_q    <= '0;
            stop_q       <= '1;
            brake_q      <= 1'b1;
            busy_q       <= 1'b0;
            round_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            to_cnt_q     <= to_cnt_d;
            ptr_q        <= ptr_d;
            round_mask_q <= round_mask_d;
            fault_q      <= fault_d;
            zero_q       <= zero_d;
            pid_start_q  <= pid_start_d;
            pid_chn_q    <= pid_chn_d;
            stop_q       <= stop_d;
            brake_q      <= brake_d;
            busy_q       <= busy_d;
            round_done_q <= round_done_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    assign pid_start   = pid_start_q;
    assign pid_chn     = pid_chn_q;
    assign stop        = stop_q;
    assign brake       = brake_q;
    assign busy        = busy_q;
    assign round_done  = round_done_q;
    assign overrun_err = overrun_q;
    assign timeout_err = timeout_q;

endmodule
`default_nettype wire
